// File: rtl/ysyx_2022040010_mem_router.sv
// LSU-side request router: steers one load/store at a time to the D-cache or
// the uncached port, returns data/ack as a single-cycle response, and reports errors.
module ysyx_2022040010_mem_router #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    input  logic        req_wen_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    input  logic        cache_sel_i,
    input  logic        uncache_sel_i,
    output logic        dc_valid_o,
    input  logic        dc_ready_i,
    output logic [63:0] dc_addr_o,
    output logic        dc_wen_o,
    output logic [63:0] dc_wdata_o,
    output logic [7:0]  dc_wmask_o,
    input  logic        dc_rvalid_i,
    input  logic [63:0] dc_rdata_i,
    output logic        uc_valid_o,
    input  logic        uc_ready_i,
    output logic [63:0] uc_addr_o,
    output logic        uc_wen_o,
    output logic [63:0] uc_wdata_o,
    output logic [7:0]  uc_wmask_o,
    input  logic        uc_rvalid_i,
    input  logic [63:0] uc_rdata_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [7:0]       wmask_q, wmask_d;
    logic             tgt_uc_q, tgt_uc_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sel_ready;
    logic             sel_rvalid;
    logic [63:0]      sel_rdata;
    logic             term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            tgt_uc_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            drain_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            tgt_uc_q <= tgt_uc_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
        end
    end

    // Only the latched target port is ever listened to.
    assign sel_ready  = tgt_uc_q ? uc_ready_i  : dc_ready_i;
    assign sel_rvalid = tgt_uc_q ? uc_rvalid_i : dc_rvalid_i;
    assign sel_rdata  = tgt_uc_q ? uc_rdata_i  : dc_rdata_i;
    assign term       = (cnt_q >= TERM_CNT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        tgt_uc_d = tgt_uc_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        drain_d  = drain_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    wen_d    = req_wen_i;
                    wdata_d  = req_wdata_i;
                    wmask_d  = req_wmask_i;
                    tgt_uc_d = uncache_sel_i;
                    rdata_d  = '0;
                    drain_d  = 1'b0;
                    cnt_d    = '0;
                    if (cache_sel_i ^ uncache_sel_i) begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_ready) begin
                    state_d = S_WAIT;
                end else if (term) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_rvalid) begin
                    rdata_d = wen_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (term) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    drain_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A stray response landing during the error pulse already satisfies the drain.
                if (drain_q && !sel_rvalid) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
                drain_d = 1'b0;
            end
            S_DRAIN: begin
                if (sel_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);

    assign dc_valid_o   = (state_q == S_ISSUE) && !tgt_uc_q;
    assign dc_addr_o    = dc_valid_o ? addr_q  : '0;
    assign dc_wen_o     = dc_valid_o & wen_q;
    assign dc_wdata_o   = dc_valid_o ? wdata_q : '0;
    assign dc_wmask_o   = dc_valid_o ? wmask_q : '0;

    assign uc_valid_o   = (state_q == S_ISSUE) && tgt_uc_q;
    assign uc_addr_o    = uc_valid_o ? addr_q  : '0;
    assign uc_wen_o     = uc_valid_o & wen_q;
    assign uc_wdata_o   = uc_valid_o ? wdata_q : '0;
    assign uc_wmask_o   = uc_valid_o ? wmask_q : '0;

    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
    assign resp_err_o   = resp_valid_o & err_q;

endmodule
